conv2_filter_scheduler: RTL
===========================

Name: conv2_filter_scheduler

Overview:
- Top-level sequencer for the second convolution layer.
- The layer datapath (window generator + N-channel systolic array) produces one output filter per pass over the 222x222 first-layer feature map.
- This block loops over all output filters. For each filter it fetches NUM_CHANNELS 3x3 kernels from weight memory, assembles them into the packed weights bus, and pulses load_weight. It then enables one frame stream and counts conv_out_valid until the full output map for that filter is produced.

Parameters:
- DATA_WIDTH, 8, bits per weight
- NUM_CHANNELS, 64, input channels (kernels per filter)
- NUM_FILTERS, 64, output filters sequenced per run
- OUT_SIZE, 220, output map side; a filter pass ends after OUT_SIZE*OUT_SIZE results
- WADDR_W, 12, weight memory address width; must be >= clog2(NUM_FILTERS*NUM_CHANNELS)
- TIMEOUT, 4096, stall limit in cycles (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin a run; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until DONE
- done  out  1  1-cycle pulse at end of run
- wmem_rd  out  1  weight memory read strobe
- wmem_addr  out  WADDR_W  read address = filter*NUM_CHANNELS + ch
- wmem_data  in  9*DATA_WIDTH  one 3x3 kernel; valid exactly 1 cycle after wmem_rd
- weights  out  NUM_CHANNELS*9*DATA_WIDTH  packed kernels; channel ch occupies slice [ch*9*DATA_WIDTH +: 9*DATA_WIDTH]
- load_weight  out  1  1-cycle pulse to the systolic array
- stream_en  out  1  permits upstream to send pixels of one frame
- conv_out_valid  in  1  result strobe from the systolic array
- filter_idx  out  clog2(NUM_FILTERS)  filter currently being computed
- timeout_err  out  1  sticky error flag (optional feature only; tied 0 otherwise)

Behaviour:
- Reset values: state=IDLE; busy, done, wmem_rd, load_weight, stream_en, timeout_err = 0; wmem_addr, filter_idx, weights, all counters = 0.
- Reset mid-operation aborts immediately to IDLE with the values above. Weights are also cleared.
- States: IDLE, FETCH, WAIT, LOAD, STREAM, NEXT, DONE.
- IDLE: start=1 -> FETCH, busy=1, filter_idx=0, ch=0.
- FETCH: wmem_rd=1 for NUM_CHANNELS consecutive cycles, wmem_addr = filter_idx*NUM_CHANNELS+ch, ch increments each cycle. After the last read -> WAIT.
- Data capture: a registered rd_d/ch_d pipeline writes wmem_data into the slice for ch_d one cycle after each read. This applies in FETCH and WAIT.
- WAIT: 1 cycle while the last kernel is captured -> LOAD.
- LOAD: load_weight=1 for exactly 1 cycle. weights is stable here and stays stable through STREAM -> STREAM.
- STREAM: stream_en=1. Count conv_out_valid pulses. On the pulse that brings the count to OUT_SIZE*OUT_SIZE, stream_en drops the following cycle -> NEXT.
- NEXT: if filter_idx==NUM_FILTERS-1 -> DONE; else filter_idx+1, ch=0 -> FETCH.
- DONE: done=1 for 1 cycle, busy=0 the following cycle -> IDLE.
- Latency: start accepted at cycle t gives first wmem_rd at t+1 and load_weight at t+NUM_CHANNELS+2. stream_en rises at t+NUM_CHANNELS+3.
- start while busy is ignored. start held high continuously causes a new run on the cycle after DONE returns to IDLE.
- conv_out_valid outside STREAM is ignored and not counted.
- Result counter width is clog2(OUT_SIZE*OUT_SIZE+1). The counter clears on entering FETCH.
- A single-cycle conv_out_valid counts once. Back-to-back pulses count every cycle.

Optional Feature:
- Macro: CONV2_SCHED_TIMEOUT_EN.
- Defined: a stall counter counts STREAM cycles since the last conv_out_valid, or since STREAM entry. On reaching TIMEOUT the block sets timeout_err=1 (sticky until rst), drops stream_en, and goes directly to DONE. done pulses normally; filter_idx holds the failing filter.
- Not defined: no stall counter, timeout_err tied 0, STREAM waits indefinitely.

Test Plan (NUM_CHANNELS=2, NUM_FILTERS=3, OUT_SIZE=2, DATA_WIDTH=8):
- Reset then start at cycle 0 -> wmem_rd at cycles 1-2 with addr 0,1; load_weight at cycle 4; stream_en rises at cycle 5; busy=1 from cycle 1.
- Memory returns 0x11.. for addr 0 and 0x22.. for addr 1 -> at load_weight, weights[71:0] all 0x11 and weights[143:72] all 0x22.
- 4 conv_out_valid pulses per filter, including 2 back-to-back -> stream_en drops after the 4th. Next reads use addr 2,3 with filter_idx=1, then addr 4,5 with filter_idx=2. One done pulse after filter 2.
- start pulses during FETCH/STREAM, and conv_out_valid pulses in IDLE/FETCH -> no effect on the sequence or the counts.
- rst asserted during STREAM of filter 1 -> next cycle all outputs 0 and state IDLE. A new start restarts at addr 0.
- With CONV2_SCHED_TIMEOUT_EN and TIMEOUT=8, no conv_out_valid in STREAM -> after 8 cycles timeout_err=1, then stream_en=0, then done pulses. timeout_err stays 1 until rst.

Source files
------------

// File: rtl/conv2_filter_scheduler.sv
// conv2_filter_scheduler: sequences the second convolution layer over all output filters.
// For each filter the block:
//   - reads NUM_CHANNELS 3x3 kernels from weight memory,
//   - packs them into the weights bus and pulses load_weight,
//   - opens one frame stream and counts results until the output map is complete.
// Optional build macro: CONV2_SCHED_TIMEOUT_EN
//   - adds a STREAM stall watchdog and a sticky timeout_err flag.
//
// state  | meaning
// IDLE   | waiting for start
// FETCH  | one weight read per cycle, NUM_CHANNELS cycles
// WAIT   | last kernel lands in the weights register
// LOAD   | load_weight pulse; weights frozen from here through STREAM
// STREAM | frame enabled, counting conv_out_valid
// NEXT   | advance to the next filter or finish
// DONE   | done pulse, busy still high
module conv2_filter_scheduler #(
    parameter int DATA_WIDTH   = 8,
    parameter int NUM_CHANNELS = 64,
    parameter int NUM_FILTERS  = 64,
    parameter int OUT_SIZE     = 220,
    parameter int WADDR_W      = 12,
    parameter int TIMEOUT      = 4096,
    localparam int KW = 9 * DATA_WIDTH,
    localparam int FW = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic                         wmem_rd,
    output logic [WADDR_W-1:0]           wmem_addr,
    input  logic [KW-1:0]                wmem_data,
    output logic [NUM_CHANNELS*KW-1:0]   weights,
    output logic                         load_weight,
    output logic                         stream_en,
    input  logic                         conv_out_valid,
    output logic [FW-1:0]                filter_idx,
    output logic                         timeout_err
);

    localparam int CW    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int TOTAL = OUT_SIZE * OUT_SIZE;
    localparam int RW    = $clog2(TOTAL + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_LOAD,
        ST_STREAM,
        ST_NEXT,
        ST_DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   ch;
    logic [CW-1:0]   ch_d;
    logic            rd_d;
    logic [RW-1:0]   res_cnt;
    logic            last_ch;
    logic            last_filter;
    logic            pass_done;
    logic            stall_hit;

    assign last_ch     = (ch == CW'(NUM_CHANNELS - 1));
    assign last_filter = (filter_idx == FW'(NUM_FILTERS - 1));
    assign pass_done   = (state == ST_STREAM) && conv_out_valid && (res_cnt == RW'(TOTAL - 1));

`ifdef CONV2_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] stall_cnt;

    assign stall_hit = (state == ST_STREAM) && !conv_out_valid && (stall_cnt == TW'(TIMEOUT - 1));

    // Stall watchdog: cycles in STREAM since entry or since the last result.
    always_ff @(posedge clk) begin
        if (rst || state != ST_STREAM || conv_out_valid) begin
            stall_cnt <= '0;
        end else begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_err <= 1'b0;
        end else if (stall_hit) begin
            timeout_err <= 1'b1;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg  = (TIMEOUT > 0);
    assign stall_hit   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        state_nxt   = state;
        busy        = 1'b1;
        done        = 1'b0;
        wmem_rd     = 1'b0;
        wmem_addr   = '0;
        load_weight = 1'b0;
        stream_en   = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                wmem_rd   = 1'b1;
                wmem_addr = WADDR_W'(filter_idx) * WADDR_W'(NUM_CHANNELS) + WADDR_W'(ch);
                if (last_ch) state_nxt = ST_WAIT;
            end
            ST_WAIT: state_nxt = ST_LOAD;
            ST_LOAD: begin
                load_weight = 1'b1;
                state_nxt   = ST_STREAM;
            end
            ST_STREAM: begin
                stream_en = 1'b1;
                if (pass_done) state_nxt = ST_NEXT;
                else if (stall_hit) state_nxt = ST_DONE;
            end
            ST_NEXT: state_nxt = last_filter ? ST_DONE : ST_FETCH;
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Channel, filter and result counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            ch         <= '0;
            filter_idx <= '0;
            res_cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        ch         <= '0;
                        filter_idx <= '0;
                        res_cnt    <= '0;
                    end
                end
                ST_FETCH: ch <= last_ch ? '0 : ch + 1'b1;
                ST_STREAM: begin
                    if (conv_out_valid) res_cnt <= res_cnt + 1'b1;
                end
                ST_NEXT: begin
                    if (!last_filter) begin
                        filter_idx <= filter_idx + 1'b1;
                        ch         <= '0;
                        res_cnt    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Read-data pipeline: memory answers one cycle after each read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_d <= 1'b0;
            ch_d <= '0;
        end else begin
            rd_d <= (state == ST_FETCH);
            ch_d <= ch;
        end
    end

    // Kernel capture into the packed weights bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            weights <= '0;
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (rd_d && ch_d == CW'(c)) weights[c*KW +: KW] <= wmem_data;
            end
        end
    end

endmodule
